// File: rtl/nonlinear_term_seq.sv
// Streams the nonlinear carry terms of an NBIT ripple adder, one per handshake.
// Optional running parity output: define NLSEQ_PARITY_EN.
module nonlinear_term_seq #(
  parameter int NBIT = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [NBIT-1:0]                          a,
  input  logic [NBIT-1:0]                          b,
  input  logic                                     c,
  output logic                                     busy,
  output logic                                     term_valid,
  input  logic                                     term_ready,
  output logic                                     term_data,
  output logic [$clog2(2**(NBIT+2)-NBIT-4)-1:0]    term_idx,
  output logic [$clog2(NBIT)-1:0]                  term_bit,
  output logic                                     done
`ifdef NLSEQ_PARITY_EN
  ,
  output logic                                     parity
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // EMIT  | presenting terms, advancing on handshake
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam int NTOT  = 2**(NBIT+2) - NBIT - 4;
  localparam int IW    = $clog2(NTOT);
  localparam int BW    = $clog2(NBIT);
  localparam int PW    = NBIT + 1;
  localparam int DEPTH = 2**(NBIT+1) - 1;

  state_t          state_q, state_d;
  logic [NBIT-1:0] a_q, b_q;
  logic [IW-1:0]   idx_q;
  logic [BW-1:0]   bit_q;
  logic [PW-1:0]   pos_q;
  logic            rd_sel_q;
  logic            buf0 [DEPTH];
  logic            buf1 [DEPTH];

  logic            start_acc, hs, last_term, last_in_blk;
  logic [PW-1:0]   s_len, rd_addr;
  logic            prev_bit, raw_term;

  assign start_acc = (state_q == IDLE) && start;
  assign hs        = term_valid && term_ready;
  assign last_term = (idx_q == IW'(NTOT-1));

  // s_len is the length of the previous block; this block is 2*s_len+1 long
  always_comb begin
    s_len       = (PW'(2) << bit_q) - PW'(1);
    last_in_blk = (pos_q == (s_len << 1));
    rd_addr     = '0;
    if (pos_q != '0) begin
      if (pos_q <= s_len) rd_addr = pos_q - PW'(1);
      else                rd_addr = pos_q - PW'(1) - s_len;
    end
    prev_bit = rd_sel_q ? buf1[rd_addr] : buf0[rd_addr];
    if (pos_q == '0)         raw_term = a_q[bit_q] & b_q[bit_q];
    else if (pos_q <= s_len) raw_term = a_q[bit_q] & prev_bit;
    else                     raw_term = b_q[bit_q] & prev_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    term_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = EMIT;
      end
      EMIT: begin
        term_valid = 1'b1;
        if (term_ready && last_term) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign term_data = term_valid ? raw_term : 1'b0;
  assign term_idx  = idx_q;
  assign term_bit  = bit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      bit_q    <= '0;
      pos_q    <= '0;
      rd_sel_q <= 1'b0;
    end else if (start_acc) begin
      a_q      <= a;
      b_q      <= b;
      idx_q    <= '0;
      bit_q    <= '0;
      pos_q    <= '0;
      rd_sel_q <= 1'b0;
    end else if (hs && !last_term) begin
      idx_q <= idx_q + 1'b1;
      if (last_in_blk) begin
        pos_q    <= '0;
        bit_q    <= bit_q + 1'b1;
        rd_sel_q <= ~rd_sel_q;
      end else begin
        pos_q <= pos_q + 1'b1;
      end
    end
  end

  // The carry-in seeds the "previous block" for bit 0
  always_ff @(posedge clk) begin
    if (start_acc) begin
      buf0[0] <= c;
    end else if (hs) begin
      if (rd_sel_q) buf0[pos_q] <= term_data;
      else          buf1[pos_q] <= term_data;
    end
  end

`ifdef NLSEQ_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)         parity <= 1'b0;
    else if (start_acc) parity <= 1'b0;
    else if (hs)        parity <= parity ^ term_data;
  end
`endif

endmodule

// File: tb/tb_nonlinear_term_seq.sv
// Randomized bench for nonlinear_term_seq against a queue-based term model.
module tb_nonlinear_term_seq;

  localparam int NBIT = 4;
  localparam int NTOT = 56;

  logic       clk = 1'b0;
  logic       rst_n, start, c, term_ready;
  logic [3:0] a, b;
  logic       busy, term_valid, term_data, done;
  logic [5:0] term_idx;
  logic [1:0] term_bit;
`ifdef NLSEQ_PARITY_EN
  logic       parity;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_data [NTOT];
  int exp_bit  [NTOT];
  bit exp_par;

  always #5 clk = ~clk;

  nonlinear_term_seq #(.NBIT(NBIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .term_valid(term_valid), .term_ready(term_ready),
    .term_data(term_data), .term_idx(term_idx), .term_bit(term_bit),
    .done(done)
`ifdef NLSEQ_PARITY_EN
    , .parity(parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Each block: [a_j&b_j, a_j&prev..., b_j&prev...]; prev starts as [c]
  function automatic void build(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    bit prev[$];
    bit cur[$];
    int n = 0;
    prev = {ic};
    exp_par = 1'b0;
    for (int j = 0; j < NBIT; j++) begin
      cur = {};
      cur.push_back(ia[j] & ib[j]);
      foreach (prev[i]) cur.push_back(ia[j] & prev[i]);
      foreach (prev[i]) cur.push_back(ib[j] & prev[i]);
      foreach (cur[i]) begin
        exp_data[n] = cur[i];
        exp_bit[n]  = j;
        exp_par    ^= cur[i];
        n++;
      end
      prev = cur;
    end
  endfunction

  task automatic reset_outputs(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, term_valid, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_data"},  term_data, 0);
    chk({tag, "_idx"},   term_idx, 0);
    chk({tag, "_bit"},   term_bit, 0);
`ifdef NLSEQ_PARITY_EN
    chk({tag, "_par"},   parity, 0);
`endif
  endtask

  task automatic run_seq(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                         input int stall_at, input int restart_at, input int reset_at,
                         input bit rnd);
    int  k = 0;
    int  stall_cnt = 0;
    int  cyc;
    bit  fin = 0;
    bit  restarted = 0;
    build(ia, ib, ic);
    @(negedge clk);
    a = ia; b = ib; c = ic; start = 1'b1; term_ready = 1'b1;
    for (cyc = 1; cyc <= 1000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      if (done) begin
        chk("done_k", k, NTOT);
        chk("done_valid", term_valid, 0);
        chk("done_busy", busy, 1);
        if (stall_at < 0 && !rnd) chk("done_latency", cyc, 57);
`ifdef NLSEQ_PARITY_EN
        chk("done_parity", parity, exp_par);
`endif
        if (restart_at >= 0) start = 1'b1;
        fin = 1;
      end else if (k >= NTOT) begin
        chk("overrun_k", k, NTOT - 1);
        fin = 1;
      end else begin
        chk("emit_busy", busy, 1);
        chk("emit_valid", term_valid, 1);
        chk("term_idx", term_idx, k);
        chk("term_data", term_data, exp_data[k]);
        chk("term_bit", term_bit, exp_bit[k]);
        if (reset_at >= 0 && k == reset_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          reset_outputs("midrst");
          @(negedge clk);
          reset_outputs("midrst_hold");
          return;
        end
        if (k == stall_at && stall_cnt < 5) begin
          term_ready = 1'b0;
          stall_cnt++;
        end else if (rnd) begin
          term_ready = ($urandom_range(3) != 0);
        end else begin
          term_ready = 1'b1;
        end
        if (restart_at >= 0 && k == restart_at && !restarted) begin
          start = 1'b1;
          restarted = 1;
        end
        if (term_ready) k++;
      end
    end
    if (!fin) chk("timeout_cycles", cyc, 0);
    @(negedge clk);
    start = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
`ifdef NLSEQ_PARITY_EN
    chk("post_parity_hold", parity, exp_par);
`endif
    @(negedge clk);
    chk("post2_busy", busy, 0);
    chk("post2_done", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0; term_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_outputs("por");
    rst_n = 1'b1;

    run_seq(4'hF, 4'hF, 1'b1, -1, -1, -1, 0);
    run_seq(4'b0001, 4'h0, 1'b1, -1, -1, -1, 0);
    run_seq(4'hA, 4'h5, 1'b0, 10, -1, -1, 0);
    run_seq(4'($urandom), 4'($urandom), 1'($urandom), -1, 20, -1, 0);
    run_seq(4'($urandom), 4'($urandom), 1'($urandom), -1, -1, 30, 0);
    run_seq(4'($urandom), 4'($urandom), 1'($urandom), -1, -1, -1, 1);
    for (int r = 0; r < 4; r++)
      run_seq(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(55), -1, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nonlinear_term_seq.md
NONLINEAR_TERM_SEQ -- requirements
Module: nonlinear_term_seq

Interface
REQ-001 Parameter NBIT, default 4, adder operand width in bits; legal range 2..6.
REQ-002 Derived constant NTOT = 2**(NBIT+2)-NBIT-4, total nonlinear terms (56 for NBIT=4); not overridable.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start  in  1  request to launch one term sequence; sampled only in IDLE.
REQ-006 a, b  in  NBIT each  adder operands, captured on accepted start.
REQ-007 c  in  1  carry-in, captured on accepted start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 term_valid  out  1  term_data/term_idx/term_bit hold a valid term.
REQ-010 term_ready  in  1  consumer accepts the term when high with term_valid.
REQ-011 term_data  out  1  value of the current nonlinear term.
REQ-012 term_idx  out  clog2(NTOT)  global index of the current term, 0..NTOT-1.
REQ-013 term_bit  out  clog2(NBIT)  operand bit position j of the current term.
REQ-014 done  out  1  one-cycle pulse after the final term is accepted.
REQ-015 parity  out  1  running XOR of accepted terms; present only with NLSEQ_PARITY_EN.

Function
REQ-016 Term order: block j (j=0..NBIT-1) = [a_j&b_j, a_j&P[0..S-1], b_j&P[0..S-1]], where P is block j-1 (P=[c] for j=0) and S=len(P); block j length = 2**(j+2)-1; blocks emitted j=0 upward.
REQ-017 The previous block's values are held in one buffer and the current block's values are written into a second buffer as emitted; buffer roles swap at each block boundary; buffer depth = 2**(NBIT+1)-1.
REQ-018 States IDLE, EMIT, DONE; IDLE->EMIT on start=1 (captures a, b, c, clears indices); EMIT->DONE on the handshake of term NTOT-1; DONE->IDLE unconditionally after one cycle.
REQ-019 Start sampled high in IDLE at edge t -> term_valid=1 with term_idx=0 from edge t+1 onward.
REQ-020 In EMIT, term_valid=1 continuously; the term advances only on term_valid&term_ready; throughput one term per cycle with term_ready held high.
REQ-021 While term_ready=0, term_data, term_idx and term_bit remain stable.
REQ-022 done=1 and term_valid=0 for exactly the DONE cycle; busy=1 in DONE.
REQ-023 start in EMIT or DONE is ignored; a, b, c changes after capture have no effect.
REQ-024 term_idx increments by 1 per handshake, never wraps within a sequence; term_bit increments at each block boundary.

Reset
REQ-025 rst_n=0 at a rising edge forces IDLE; busy=0, term_valid=0, done=0, term_data=0, term_idx=0, term_bit=0, parity=0; buffers need no clearing.
REQ-026 Reset asserted mid-EMIT aborts the sequence without a done pulse; the first start after reset release begins a fresh sequence at term_idx=0.

Configuration
REQ-027 Macro NLSEQ_PARITY_EN defined: port parity exists, clears on accepted start, XORs term_data on every handshake, holds its value through DONE and IDLE until the next start.
REQ-028 NLSEQ_PARITY_EN undefined: no parity port and no parity logic; all other behaviour identical.

Verification (NBIT=4)
REQ-029 a=4'hF, b=4'hF, c=1, term_ready=1 -> 56 terms, all term_data=1, done pulse 57 cycles after start edge, parity=0.
REQ-030 a=4'b0001, b=0, c=1 -> only term_idx=1 has term_data=1, all other terms 0, parity=1.
REQ-031 a=4'hA, b=4'h5, c=0, term_ready held low for 5 cycles at term_idx=10 -> outputs stable during the stall, sequence resumes at idx 10, no term lost or duplicated; every term matches the REQ-016 reference model.
REQ-032 start pulsed again at term_idx=20 and during DONE -> ignored, exactly one done pulse, idx sequence unbroken.
REQ-033 rst_n low for 1 cycle at term_idx=30 -> next edge all outputs at reset values, no done pulse; new start emits from term_idx=0.
